// File: rtl/aes_128_enc.sv
// Iterative AES-128 encryptor (encrypt only).
// One round datapath is reused across a fixed 10-cycle frame. Inputs are
// captured on the edge that closes the ready cycle (ph==0). Rounds 1..9 are
// registered, and the final round is combinational while ph==9.
module aes_128_enc (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_bus,
    input  logic [127:0] key,
    output logic [127:0] out_bus,
    output logic         ready,
    output logic         valid
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state lives at bits [8*(15-i) +: 8]; byte i = row i%4, column i/4.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        sub_bytes = r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int unsigned row = 0; row < 4; row++) begin
            for (int unsigned col = 0; col < 4; col++) begin
                r[8*(15 - (row + 4*col)) +: 8] =
                    s[8*(15 - (row + 4*((col + row) % 4))) +: 8];
            end
        end
        shift_rows = r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int unsigned col = 0; col < 4; col++) begin
            a0 = s[8*(15 - 4*col)     +: 8];
            a1 = s[8*(15 - 4*col - 1) +: 8];
            a2 = s[8*(15 - 4*col - 2) +: 8];
            a3 = s[8*(15 - 4*col - 3) +: 8];
            r[8*(15 - 4*col)     +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[8*(15 - 4*col - 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[8*(15 - 4*col - 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[8*(15 - 4*col - 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        mix_columns = r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, t;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rc, 24'h000000};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        key_expand = {w0, w1, w2, w3};
    endfunction

    logic [3:0]   ph_q, ph_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic         have_q, have_d;

    logic [7:0]   rcon;
    logic [127:0] key_base, st_base, rk_next, sr, round_out, final_out;

    // Round constant indexed directly by phase; ph==9 supplies the final-round constant.
    always_comb begin
        case (ph_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            default: rcon = 8'h36;
        endcase
    end

    // Shared round datapath: at ph==0 the source is the fresh input whitened by the key.
    always_comb begin
        key_base  = (ph_q == 4'd0) ? key : rk_q;
        st_base   = (ph_q == 4'd0) ? (in_bus ^ key) : state_q;
        rk_next   = key_expand(key_base, rcon);
        sr        = shift_rows(sub_bytes(st_base));
        round_out = mix_columns(sr) ^ rk_next;
        final_out = sr ^ rk_next;
    end

    // Next-state: advance rounds during ph 0..8 and hold during the output cycle.
    always_comb begin
        ph_d    = (ph_q == 4'd9) ? 4'd0 : ph_q + 4'd1;
        state_d = state_q;
        rk_d    = rk_q;
        have_d  = have_q;
        if (ph_q != 4'd9) begin
            state_d = round_out;
            rk_d    = rk_next;
        end
        if (ph_q == 4'd8) begin
            have_d = 1'b1;
        end
    end

    // Registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q    <= 4'd9;
            state_q <= '0;
            rk_q    <= '0;
            have_q  <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            have_q  <= have_d;
        end
    end

    // Outputs decoded from phase; ciphertext gated to zero outside the valid cycle.
    always_comb begin
        ready   = (ph_q == 4'd0);
        valid   = (ph_q == 4'd9) && have_q;
        out_bus = valid ? final_out : '0;
    end

endmodule

// File: tb/tb_aes_128_enc.sv
// Bench for aes_128_enc: byte-array AES reference with an arithmetically
// derived S-box, a per-cycle compare process, and literal FIPS-197 vectors.
module tb_aes_128_enc;

    logic         clk;
    logic         rst;
    logic [127:0] in_bus;
    logic [127:0] key;
    logic [127:0] out_bus;
    logic         ready;
    logic         valid;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb_tab [256];

    int   n     = 0;
    bit   known = 0;
    logic [127:0] exp_ct = '0;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_128_enc dut (
        .clk     (clk),
        .rst     (rst),
        .in_bus  (in_bus),
        .key     (key),
        .out_bus (out_bus),
        .ready   (ready),
        .valid   (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        logic [15:0] d;
        d = {x, x} << s;
        return d[15:8];
    endfunction

    // S-box from the definition: multiplicative inverse in GF(2^8) then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] a8;
        for (int a = 0; a < 256; a++) begin
            a8  = 8'(a);
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(a8, 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   st  [16];
        logic [7:0]   tmp [16];
        logic [31:0]  w   [44];
        logic [7:0]   rc;
        logic [31:0]  t;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++)
            st[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) st[i] = sb_tab[st[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r + 4*c] = st[r + 4*((c + r) % 4)];
            for (int i = 0; i < 16; i++) st[i] = tmp[i];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++)
                st[i] = st[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Non-reset edges since the most recent reset edge.
    always @(posedge clk) begin
        if (rst) begin
            n     = 0;
            known = 1'b1;
        end else if (known) begin
            n = n + 1;
        end
    end

    // Per-cycle expectations derived from the edge count since reset.
    always @(negedge clk) begin
        if (known) begin
            check1("ready_shape", ready, (n % 10 == 1));
            check1("valid_shape", valid, (n >= 10) && (n % 10 == 0));
            if ((n >= 10) && (n % 10 == 0))
                check128("out_model", out_bus, exp_ct);
            else
                check128("out_zero", out_bus, '0);
            if (n % 10 == 1)
                exp_ct = aes_ref(in_bus, key);
        end
    end

    task automatic run_frame(input logic [127:0] p, input logic [127:0] k,
                             input bit lit, input logic [127:0] req);
        check1("frame_ready", ready, 1'b1);
        in_bus = p;
        key    = k;
        for (int i = 0; i < 9; i++) begin
            cycle();
            in_bus = rnd128();
            key    = rnd128();
        end
        check1("frame_valid", valid, 1'b1);
        if (lit) check128("frame_literal", out_bus, req);
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        in_bus = rnd128();
        key    = rnd128();

        build_sbox();
        check128("sbox_00", {120'h0, sb_tab[8'h00]}, 128'h63);
        check128("sbox_53", {120'h0, sb_tab[8'h53]}, 128'hed);
        check128("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
        check128("model_b", aes_ref(B_PT, B_KEY), B_CT);
        check128("model_zero", aes_ref('0, '0), Z_CT);

        repeat (3) begin
            cycle();
            check1("rst_ready", ready, 1'b0);
            check1("rst_valid", valid, 1'b0);
            check128("rst_out", out_bus, '0);
            in_bus = rnd128();
            key    = rnd128();
        end
        rst = 1'b0;
        check1("release_ready", ready, 1'b0);
        cycle();

        run_frame(C1_PT, C1_KEY, 1'b1, C1_CT);
        run_frame(B_PT, B_KEY, 1'b1, B_CT);
        run_frame('0, '0, 1'b1, Z_CT);
        for (int f = 0; f < 20; f++) run_frame(rnd128(), rnd128(), 1'b0, '0);

        // Abort a frame at ph=5 with reset.
        check1("abort_ready", ready, 1'b1);
        in_bus = C1_PT;
        key    = C1_KEY;
        repeat (5) begin
            cycle();
            in_bus = rnd128();
            key    = rnd128();
        end
        rst = 1'b1;
        repeat (3) begin
            cycle();
            check1("abort_valid", valid, 1'b0);
            check1("abort_ready_low", ready, 1'b0);
            check128("abort_out", out_bus, '0);
        end
        rst = 1'b0;
        cycle();
        run_frame(C1_PT, C1_KEY, 1'b1, C1_CT);
        run_frame(rnd128(), rnd128(), 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_128_enc.md
Name: aes_128_enc

Overview:
- Iterative AES-128 encryptor (FIPS-197, encrypt only), one round datapath reused over a fixed 10-cycle frame.
- Free-running: accepts one plaintext/key pair per frame with no input handshake, and presents the ciphertext at the end of the same frame.
- Used as a standalone crypto block fed by a sequencer that aligns stimulus to the `ready` cycle.

Parameters:
- None. Block size and key size are fixed at 128 bits; round count is fixed at 10.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_bus  input  128  plaintext; byte 0 = in_bus[127:120], column-major state as in FIPS-197
- key  input  128  cipher key, same byte order
- out_bus  output  128  ciphertext, same byte order; 0 when valid=0
- ready  output  1  high during the cycle whose closing edge samples in_bus/key
- valid  output  1  high for exactly the one cycle in which out_bus holds a result

Behaviour:
- Phase counter `ph`, 0..9, wraps 9→0 every cycle. On reset: ph=9, state=0, round-key register=0, have_result=0.
- Reset is synchronous, checked every edge, and overrides everything. Reset mid-frame aborts the frame with no output.
- First edge with rst=0: ph 9→0. Inputs are sampled on the next edge, which is the second edge after reset release.
- ready = (ph==0), combinational from ph. valid = (ph==9) & have_result.
- Edge with ph==0, which sample inputs unconditionally:
  - state <= Round(in_bus ^ key, rk1), where Round = SubBytes, ShiftRows, MixColumns, then AddRoundKey.
  - rk <= rk1 = KeyExpand(key, rcon=01).
- Edges with ph==1..8: rk <= KeyExpand(rk, rcon[ph+1]); state <= Round(state, that new key). This covers rounds 2..9. rcon sequence: 01 02 04 08 10 20 40 80 1b 36.
- Edge ph 8→9: have_result <= 1.
- Final round is combinational during ph==9: out_bus = ShiftRows(SubBytes(state)) ^ KeyExpand(rk, rcon=36), with no MixColumns.
- out_bus is forced to 0 whenever valid=0.
- Latency: inputs sampled at edge E; result valid in the cycle after edge E+8. Throughput: 1 block per 10 cycles.
- in_bus/key values on any cycle with ready=0 are ignored entirely. Each frame is independent, with no state carried between frames.
- have_result stays 1 after the first completion until the next reset.
- S-box is a constant 256-entry table shared as a function; 20 instances are needed (16 state + 4 key).
- MixColumns uses xtime (shift left, conditionally XOR 0x1b) in GF(2^8).
- No X on any output after reset.

Test Plan:
- After reset release, apply in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f on the ready cycle; randomize inputs on all other cycles.
  -> valid=1 exactly 9 cycles later, with out_bus=69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back frames:
  - in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32.
  - Next frame, in=0, key=0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - ready pulses every 10 cycles.
- Reset sequencing -> ready=0, valid=0, out_bus=0 while rst=1. ready rises on the first cycle after the first non-reset edge. No valid before the first completed frame.
- Assert rst at ph=5 of a frame -> no valid pulse for that frame. The next frame starts 2 edges after release and produces the correct FIPS-197 result.
- Garbage immunity: drive random values on in_bus/key on every non-ready cycle over 20 frames -> every result matches the reference model of the ready-cycle sample.
- Signal shape: valid is high exactly one cycle per frame, ready and valid are never high together, and out_bus=0 on all non-valid cycles.
